// File: rtl/uart_port.sv
// rtl/uart_port.sv - memory-bus slave 8N1 UART with TX FIFO and 1-deep RX holding register
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   cs, wen, addr   bus select, write enable, register select (0 DR, 1 SR, 2 CTRL, 3 BRR)
//   din, dout       bus write data, combinational read data (no read side effects)
//   rxd, txd        serial input (asynchronous, idle high), serial output (idle high)
//   irq             level interrupt, registered
module uart_port #(
    parameter int          WIDTH     = 32,
    parameter int          FIFO_AW   = 2,
    parameter logic [15:0] BRR_RESET = 16'd86
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             rxd,
    output logic             txd,
    output logic             irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = DEPTH[FIFO_AW:0];

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [15:0] brr;
    logic [1:0]  ctrl;
    logic        wr_dr, wr_sr, wr_ctrl, wr_brr;

    assign wr_dr   = cs & wen & (addr == 2'd0);
    assign wr_sr   = cs & wen & (addr == 2'd1);
    assign wr_ctrl = cs & wen & (addr == 2'd2);
    assign wr_brr  = cs & wen & (addr == 2'd3);

    logic unused_din;
    assign unused_din = ^din[WIDTH-1:16];

    // TX FIFO
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_empty, fifo_full, push, tx_pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    // A push into a full FIFO is dropped even if the shifter pops in the same cycle.
    assign push       = wr_dr & ~fifo_full;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= din[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, tx_pop};
        end
    end

    // TX shifter
    state_t      tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick;

    assign tx_tick = (tx_cnt == 16'd0);

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE:  if (!fifo_empty) begin tx_next = S_START; tx_pop = 1'b1; end
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tick) begin
                         // Back-to-back frames: go straight to START with no idle bit.
                         if (!fifo_empty) begin tx_next = S_START; tx_pop = 1'b1; end
                         else tx_next = S_IDLE;
                     end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_cnt   <= brr;
            tx_bit   <= '0;
        end else if (tx_state != S_IDLE) begin
            if (tx_tick) begin
                // BRR is only sampled here, so a write never stretches the current bit.
                tx_cnt <= brr;
                if (tx_state == S_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        case (tx_state)
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_shift[0];
            default: txd = 1'b1;
        endcase
    end

    // RX
    logic        rx_s1, rx_s2;
    state_t      rx_state, rx_next;
    logic [15:0] rx_cnt, half_load;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_data;
    logic        rx_tick, rx_done, rx_pop;
    logic        rx_valid, rx_ovr, rx_ferr, tx_drop;

    assign rx_tick = (rx_cnt == 16'd0);
    assign rx_done = (rx_state == S_STOP) && rx_tick;
    assign rx_pop  = wr_sr & din[0];

    // Half-bit delay of (BRR+1)/2 clks expressed as a countdown load value.
    always_comb begin
        if (brr[0] || brr == 16'd0) half_load = brr >> 1;
        else                        half_load = (brr >> 1) - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (!rx_s2) rx_next = S_START;
            S_START: if (rx_tick) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) rx_state <= S_IDLE;
        else       rx_state <= rx_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == S_IDLE) begin
            rx_cnt <= half_load;
            rx_bit <= '0;
        end else if (rx_tick) begin
            rx_cnt <= brr;
            if (rx_state == S_DATA) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

    // Status, control and interrupt. Flag sets are placed after clears so a
    // simultaneous event wins over a software clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
            tx_drop  <= 1'b0;
            ctrl     <= '0;
            brr      <= BRR_RESET;
            irq      <= 1'b0;
        end else begin
            if (wr_sr && din[3]) rx_ovr  <= 1'b0;
            if (wr_sr && din[4]) rx_ferr <= 1'b0;
            if (wr_sr && din[5]) tx_drop <= 1'b0;
            if (wr_dr && fifo_full) tx_drop <= 1'b1;
            if (rx_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                if (!rx_s2) rx_ferr <= 1'b1;
                if (rx_valid && !rx_pop) rx_ovr <= 1'b1;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            if (wr_ctrl) ctrl <= din[1:0];
            if (wr_brr)  brr  <= din[15:0];
            irq <= (ctrl[0] & rx_valid) | (ctrl[1] & fifo_empty);
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            2'd0: dout[7:0]  = rx_data;
            2'd1: dout[5:0]  = {tx_drop, rx_ferr, rx_ovr,
                                fifo_empty && tx_state == S_IDLE, fifo_full, rx_valid};
            2'd2: dout[1:0]  = ctrl;
            default: dout[15:0] = brr;
        endcase
    end
endmodule

// File: tb/tb_uart_port.sv
// tb/tb_uart_port.sv - self-checking bench for uart_port
module tb_uart_port;
    logic        clk = 1'b0;
    logic        reset, cs, wen, rxd, txd, irq;
    logic [1:0]  addr;
    logic [31:0] din, dout;

    always #5 clk = ~clk;

    uart_port #(.WIDTH(32), .FIFO_AW(2), .BRR_RESET(16'd86)) dut (
        .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr),
        .din(din), .dout(dout), .rxd(rxd), .txd(txd), .irq(irq)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    bit         mon_en = 1'b1;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic sel);
        @(negedge clk);
        cs = sel; wen = 1'b1; addr = a; din = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        rx_q.push_back(b);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (4) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic wait_rxv(input string name);
        bit ok;
        ok = 1'b0;
        addr = 2'd1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (dout[0] === 1'b1) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic rx_check(input string name);
        logic [31:0] d;
        logic [7:0]  e;
        bus_rd(2'd0, d);
        e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        check(name, d, {24'd0, e});
    endtask

    // TX frame monitor, BRR=3 (4 clks/bit); compares decoded bytes with the scoreboard.
    initial begin : tx_mon
        logic [7:0] b;
        logic       stopb;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                starts.push_back(cyc);
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = txd;
                end
                repeat (4) @(negedge clk);
                stopb = txd;
                if (mon_en) begin
                    if (tx_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tx_unexpected_frame: got 0x%0h expected none", b);
                    end else begin
                        check("tx_byte", b, tx_q.pop_front());
                    end
                    check("tx_stop", stopb, 1);
                end
            end
        end
    end

    initial begin : main
        vec_t        vecs[7];
        logic [31:0] d;
        int          bad;
        bit          found;
        logic        exp_bit;

        vecs[0] = '{1'b1, 2'd3, 32'h0001_2345, 2'd3, 32'h0000_2345};
        vecs[1] = '{1'b0, 2'd3, 32'h0000_7777, 2'd3, 32'h0000_2345};
        vecs[2] = '{1'b1, 2'd2, 32'hFFFF_FFFD, 2'd2, 32'h0000_0001};
        vecs[3] = '{1'b1, 2'd2, 32'h0000_0002, 2'd2, 32'h0000_0002};
        vecs[4] = '{1'b1, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};
        vecs[5] = '{1'b1, 2'd3, 32'h0000_0003, 2'd3, 32'h0000_0003};
        vecs[6] = '{1'b1, 2'd1, 32'h0000_0039, 2'd1, 32'h0000_0004};

        reset = 1'b1; cs = 1'b0; wen = 1'b0; addr = 2'd0; din = '0; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_txd", txd, 1);
        check("rst_irq", irq, 0);
        bus_rd(2'd1, d); check("rst_sr", d, 32'h04);
        bus_rd(2'd3, d); check("rst_brr", d, 32'd86);
        bus_rd(2'd2, d); check("rst_ctrl", d, 32'h0);
        bus_rd(2'd0, d); check("rst_dr", d, 32'h0);

        // Register vectors
        for (int i = 0; i < 7; i++) begin
            bus_wr(vecs[i].wa, vecs[i].wd, vecs[i].sel);
            bus_rd(vecs[i].ra, d);
            check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
        end

        // Exact waveform of 0x55 at BRR=3
        tx_q.push_back(8'h55);
        bus_wr(2'd0, 32'h55, 1'b1);
        addr = 2'd1;
        bad = 0;
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk); #1;
            if (k == 0)       exp_bit = 1'b1;
            else if (k <= 4)  exp_bit = 1'b0;
            else if (k <= 36) exp_bit = ((8'h55 >> ((k - 5) / 4)) & 8'h01) != 8'h00;
            else              exp_bit = 1'b1;
            if (txd !== exp_bit) bad++;
            if (k == 40) check("tx_idle_early", dout[2], 0);
            if (k == 41) check("tx_idle_done", dout[2], 1);
        end
        check("tx_wave_55", bad, 0);
        repeat (5) @(negedge clk);

        // Burst: 5 pushes fill shifter + FIFO, 6th is dropped
        starts.delete();
        for (int b = 1; b <= 5; b++) begin
            tx_q.push_back(b[7:0]);
            bus_wr(2'd0, b, 1'b1);
        end
        bus_rd(2'd1, d); check("tx_full", d[1], 1);
        bus_wr(2'd0, 32'h06, 1'b1);
        bus_rd(2'd1, d); check("tx_drop", d[5], 1);
        bus_wr(2'd1, 32'h20, 1'b1);
        bus_rd(2'd1, d); check("tx_drop_clr", d[5], 0);
        for (int t = 0; t < 600 && tx_q.size() > 0; t++) @(negedge clk);
        check("tx_sb_drain", tx_q.size(), 0);
        repeat (10) @(negedge clk);
        check("tx_frames", starts.size(), 5);
        bad = 0;
        for (int i = 0; i + 1 < starts.size(); i++)
            if (starts[i+1] - starts[i] != 40) bad++;
        check("tx_b2b", bad, 0);

        // RX normal and overrun
        send_rx(8'hA3, 1'b1);
        wait_rxv("rx_valid_a3");
        rx_check("rx_byte_a3");
        send_rx(8'h3C, 1'b1);
        repeat (6) @(negedge clk);
        bus_rd(2'd1, d); check("rx_ovr_sr", d, 32'h0D);
        rx_check("rx_byte_ovr");
        bus_wr(2'd1, 32'h09, 1'b1);
        bus_rd(2'd1, d); check("rx_clr", d, 32'h04);

        // Framing error
        send_rx(8'h5A, 1'b0);
        wait_rxv("rx_valid_5a");
        bus_rd(2'd1, d); check("rx_ferr_sr", d, 32'h15);
        rx_check("rx_byte_ferr");
        bus_wr(2'd1, 32'h11, 1'b1);
        repeat (10) @(negedge clk);
        bus_rd(2'd1, d); check("rx_ferr_clr", d, 32'h04);

        // One-clock glitch: no byte, receiver still works afterwards
        @(posedge clk); #1 rxd = 1'b0;
        @(posedge clk); #1 rxd = 1'b1;
        repeat (10) @(negedge clk);
        bus_rd(2'd1, d); check("rx_glitch", d, 32'h04);
        send_rx(8'hC5, 1'b1);
        wait_rxv("rx_valid_c5");
        rx_check("rx_after_glitch");
        bus_wr(2'd1, 32'h01, 1'b1);

        // Interrupts
        bus_wr(2'd2, 32'h1, 1'b1);
        @(negedge clk); #1; check("irq_idle", irq, 0);
        send_rx(8'h96, 1'b1);
        addr = 2'd1;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk); #1;
            if (dout[0] === 1'b1) found = 1'b1;
        end
        check("irq_rx_seen", found, 1);
        check("irq_lag", irq, 0);
        @(negedge clk); #1; check("irq_rx", irq, 1);
        rx_check("rx_byte_96");
        bus_wr(2'd1, 32'h01, 1'b1);
        @(negedge clk); #1; check("irq_pop_lag", irq, 1);
        @(negedge clk); #1; check("irq_pop", irq, 0);
        bus_wr(2'd2, 32'h2, 1'b1);
        repeat (2) @(negedge clk); #1; check("irq_tx_empty", irq, 1);
        bus_wr(2'd2, 32'h0, 1'b1);
        repeat (2) @(negedge clk); #1; check("irq_off", irq, 0);

        // Reset during TX data bit 3
        mon_en = 1'b0;
        bus_wr(2'd0, 32'hF0, 1'b1);
        repeat (18) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus_rd(2'd1, d);
        check("mid_rst_txd", txd, 1);
        check("mid_rst_sr", d, 32'h04);
        bus_rd(2'd3, d); check("mid_rst_brr", d, 32'd86);
        bad = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk); #1;
            if (txd !== 1'b1) bad++;
        end
        check("mid_rst_quiet", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
